// File: rtl/icache_refill_collector_pkg.sv
// Shared icache refill definitions: default geometry, the refill payload type
// and the collector FSM state encoding.
package icache_refill_collector_pkg;

    localparam int REFILL_BEAT_W = 64;
    localparam int REFILL_BEATS  = 4;
    localparam int REFILL_ID_W   = 4;
    localparam int REFILL_LINE_W = REFILL_BEAT_W * REFILL_BEATS;

    typedef struct packed {
        logic [REFILL_LINE_W-1:0] line;
        logic [REFILL_ID_W-1:0]   id;
        logic                     err;
    } refill_pld_t;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } refill_state_e;

endpackage

// File: rtl/icache_refill_collector.sv
// Gathers memory read beats into one cache line and presents it downstream
// with a valid/ready hand-off that can overlap with beat 0 of the next line.
module icache_refill_collector
    import icache_refill_collector_pkg::*;
#(
    parameter int BEAT_W = REFILL_BEAT_W,
    parameter int BEATS  = REFILL_BEATS,
    parameter int ID_W   = REFILL_ID_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_vld,
    output logic              s_rdy,
    input  logic [BEAT_W-1:0] s_data,
    input  logic [ID_W-1:0]   s_id,
    input  logic              s_last,
    input  logic              s_err,
    input  logic              flush,
    output logic              m_vld,
    input  logic              m_rdy,
    output refill_pld_t       m_pld
);

    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    refill_state_e           r_state;
    refill_state_e           w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [BEATS*BEAT_W-1:0] r_line;
    logic [ID_W-1:0]         r_id;
    logic                    r_err;

    logic                    w_xfer;
    logic                    w_flush;
    logic                    w_take;
    logic                    w_done;
    logic                    w_first;
    logic                    w_beat_err;
    logic                    w_err_next;
    logic [ID_W-1:0]         w_id_next;
    logic [BEATS*BEAT_W-1:0] w_line_next;

    // A flush while collecting swallows any beat offered in the same cycle.
    assign w_xfer  = s_vld && s_rdy;
    assign w_flush = (r_state == ST_COLLECT) && flush;
    assign w_take  = w_xfer && !w_flush;
    assign w_first = (r_cnt == '0);
    assign w_done  = w_take && (s_last || (r_cnt == LAST_BEAT));

    assign w_beat_err = s_err
                      || (!w_first && (s_id != r_id))
                      || ((r_cnt == LAST_BEAT) && !s_last)
                      || ((r_cnt != LAST_BEAT) && s_last);
    assign w_err_next = (w_first ? 1'b0 : r_err) || w_beat_err;
    assign w_id_next  = w_first ? s_id : r_id;

    // Beat 0 starts from an all-zero line so a short burst leaves zeros above it.
    always_comb begin
        w_line_next = w_first ? '0 : r_line;
        for (int k = 0; k < BEATS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_line_next[k*BEAT_W +: BEAT_W] = s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        s_rdy        = 1'b0;
        m_vld        = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                s_rdy = rst_n;
                if (w_done) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                s_rdy = rst_n && m_rdy;
                m_vld = 1'b1;
                if (m_rdy) begin
                    w_state_next = w_done ? ST_HOLD : ST_COLLECT;
                end
            end
            default: w_state_next = ST_COLLECT;
        endcase
    end

    // The line, id and err registers double as the held payload in HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_line <= '0;
            r_id   <= '0;
            r_err  <= 1'b0;
        end else if (w_flush) begin
            r_cnt  <= '0;
            r_id   <= '0;
            r_err  <= 1'b0;
        end else if (w_take) begin
            r_line <= w_line_next;
            r_id   <= w_id_next;
            r_err  <= w_err_next;
            r_cnt  <= w_done ? '0 : r_cnt + 1'b1;
        end
    end

    assign m_pld = '{line: r_line, id: r_id, err: r_err};

endmodule

// File: tb/tb_icache_refill_collector.sv
// Randomised scoreboard bench for icache_refill_collector: a beat-list model
// predicts each completed line; a negedge monitor checks the DUT against it.
module tb_icache_refill_collector;
    import icache_refill_collector_pkg::*;

    localparam int BW = REFILL_BEAT_W;
    localparam int NB = REFILL_BEATS;
    localparam int IW = REFILL_ID_W;
    localparam int PW = $bits(refill_pld_t);

    typedef struct {
        logic [BW-1:0] data;
        logic [IW-1:0] id;
        bit            last;
        bit            err;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          s_vld;
    logic          s_rdy;
    logic [BW-1:0] s_data;
    logic [IW-1:0] s_id;
    logic          s_last;
    logic          s_err;
    logic          flush;
    logic          m_vld;
    logic          m_rdy;
    refill_pld_t   m_pld;

    int            total = 0;
    int            bad   = 0;
    refill_pld_t   expQ[$];
    beat_t         partial[$];
    bit            held = 0;

    icache_refill_collector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_vld (s_vld),
        .s_rdy (s_rdy),
        .s_data(s_data),
        .s_id  (s_id),
        .s_last(s_last),
        .s_err (s_err),
        .flush (flush),
        .m_vld (m_vld),
        .m_rdy (m_rdy),
        .m_pld (m_pld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected line straight from the beat list: placement by index, error rules per beat.
    function automatic refill_pld_t buildLine(input beat_t b[$]);
        refill_pld_t p;
        p = '0;
        p.id = b[0].id;
        for (int k = 0; k < b.size(); k++) begin
            p.line[k*BW +: BW] = b[k].data;
            if (b[k].err) p.err = 1'b1;
            if (b[k].id != b[0].id) p.err = 1'b1;
            if (b[k].last != (k == NB - 1)) p.err = 1'b1;
        end
        return p;
    endfunction

    // Reference model: evaluated on each clock edge from the values presented before it.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                held = 0;
                partial.delete();
                expQ.delete();
            end else begin
                bit wasHeld;
                bit rdy;
                wasHeld = held;
                rdy = !held || m_rdy;
                if (held && m_rdy) held = 0;
                if (!wasHeld && flush) begin
                    partial.delete();
                end else if (s_vld && rdy) begin
                    partial.push_back('{data: s_data, id: s_id, last: s_last, err: s_err});
                    if (s_last || partial.size() == NB) begin
                        expQ.push_back(buildLine(partial));
                        partial.delete();
                        held = 1;
                    end
                end
            end
        end
    end

    // Monitor: handshake outputs every cycle, payload whenever a line is offered.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            checkOutput("s_rdy", PW'(s_rdy), PW'(rst_n && (!held || m_rdy)));
            checkOutput("m_vld", PW'(m_vld), PW'(held));
            if (m_vld) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL m_pld: got %h expected no line", m_pld);
                end else begin
                    checkOutput("m_pld", m_pld, expQ[0]);
                    if (m_rdy && rst_n) void'(expQ.pop_front());
                end
            end
        end
    end

    task automatic applyStimulus(input bit vld, input logic [BW-1:0] data, input logic [IW-1:0] id,
                                 input bit last, input bit err, input bit fl, input bit mrdy);
        s_vld  = vld;
        s_data = data;
        s_id   = id;
        s_last = last;
        s_err  = err;
        flush  = fl;
        m_rdy  = mrdy;
        @(posedge clk);
        #1;
    endtask

    task automatic sendLine(input logic [IW-1:0] id, input bit mrdyLast);
        for (int k = 0; k < NB; k++) begin
            applyStimulus(1, {$urandom, $urandom}, id, k == NB - 1, 0, 0,
                          (k == NB - 1) ? mrdyLast : 1'b1);
        end
    endtask

    initial begin
        refill_pld_t ref035;
        rst_n = 1'b0;
        s_vld = 0; s_data = '0; s_id = '0; s_last = 0; s_err = 0; flush = 0; m_rdy = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("reset m_pld", m_pld, '0);
        checkOutput("reset m_vld", PW'(m_vld), '0);
        checkOutput("reset s_rdy", PW'(s_rdy), '0);
        rst_n = 1'b1;

        // Four-beat line with known data.
        applyStimulus(1, 64'h11, 3, 0, 0, 0, 1);
        applyStimulus(1, 64'h22, 3, 0, 0, 0, 1);
        applyStimulus(1, 64'h33, 3, 0, 0, 0, 1);
        applyStimulus(1, 64'h44, 3, 1, 0, 0, 0);
        ref035 = '0;
        ref035.line = {64'h44, 64'h33, 64'h22, 64'h11};
        ref035.id = 4'd3;
        checkOutput("known line m_vld", PW'(m_vld), PW'(1));
        checkOutput("known line m_pld", m_pld, ref035);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Back-to-back lines with continuous beats.
        for (int l = 0; l < 3; l++) sendLine(IW'($urandom), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Stall in HOLD for five cycles with the next beat waiting.
        sendLine(4'd1, 0);
        for (int c = 0; c < 5; c++) applyStimulus(1, 64'hAA, 4'd6, 0, 0, 0, 0);
        applyStimulus(1, 64'hAA, 4'd6, 0, 0, 0, 1);
        for (int k = 1; k < NB; k++) applyStimulus(1, 64'hB0 + k, 4'd6, k == NB - 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Early last, then an id mismatch on beat 2.
        applyStimulus(1, 64'h5, 4'd2, 0, 0, 0, 1);
        applyStimulus(1, 64'h6, 4'd2, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 64'h7, 4'd2, 0, 0, 0, 1);
        applyStimulus(1, 64'h8, 4'd2, 0, 0, 0, 1);
        applyStimulus(1, 64'h9, 4'd5, 0, 0, 0, 1);
        applyStimulus(1, 64'hA, 4'd2, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Flush mid-line, including a beat dropped alongside the flush.
        applyStimulus(1, 64'hDEAD, 4'd4, 0, 0, 0, 1);
        applyStimulus(1, 64'hBEEF, 4'd4, 0, 0, 0, 1);
        applyStimulus(1, 64'hF00D, 4'd4, 0, 0, 1, 1);
        sendLine(4'd7, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Flush while holding must not disturb the held line.
        sendLine(4'd9, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);

        // Reset in HOLD and mid-line.
        sendLine(4'd8, 0);
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset from hold m_vld", PW'(m_vld), '0);
        rst_n = 1'b1;
        applyStimulus(1, 64'h1, 4'd8, 0, 0, 0, 1);
        applyStimulus(1, 64'h2, 4'd8, 0, 0, 0, 1);
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("reset mid-line m_vld", PW'(m_vld), '0);
        rst_n = 1'b1;
        sendLine(4'd10, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [IW-1:0] id;
            bit last;
            id = (partial.size() > 0) ? partial[0].id : IW'($urandom);
            if ($urandom_range(15) == 0) id = IW'($urandom);
            last = (partial.size() == NB - 1) ? ($urandom_range(7) != 0) : ($urandom_range(9) == 0);
            rst_n = ($urandom_range(299) != 0);
            applyStimulus($urandom_range(3) != 0, {$urandom, $urandom}, id, last,
                          $urandom_range(19) == 0, $urandom_range(24) == 0, $urandom_range(2) != 0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("drained queue", PW'(expQ.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
